// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, default width, FSM encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_MUL      = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_LOW = 3'd4
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential signed multiplier: shift-add over operand magnitudes, one
// iteration per cycle, sign applied at the end. done pulses for one cycle
// after MUL_CYCLES iterations, with product/ovf valid in that cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic               running;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;

    // Magnitude as unsigned; the most negative value maps onto itself, which
    // is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Load magnitudes on start, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, mag(a)};
            acc     <= '0;
            mplier  <= mag(b);
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            if (cnt == CW'(MUL_CYCLES)) begin
                running <= 1'b0;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign done     = running && (cnt == CW'(MUL_CYCLES));
    assign prod     = neg ? ('0 - acc) : acc;
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    assign product  = prod[WIDTH-1:0];
    // Fits in signed WIDTH only if the upper half plus sign bit are all equal.
    assign ovf      = !((&prod_top) || (~|prod_top));

endmodule

// File: rtl/alu_core.sv
// Multi-cycle integer ALU behind the alu_incoming/alu_received handshake.
// Single-cycle ops complete in EXEC; op 9 runs the sequential signed
// multiplier when built with ALU_MUL_EN, otherwise it is an illegal op.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_incoming,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             alu_received,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             signov,
    output logic             alu_busy
);

    alu_state_e       state, state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept;
    logic             is_mul_req;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_ovf;

    logic [WIDTH-1:0] res_y;
    logic             res_c, res_v;
    logic [3:0]       sh;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sra_w;

    assign accept = (state == S_IDLE) && alu_incoming;

`ifdef ALU_MUL_EN
    assign is_mul_req = (alu_op == ALU_MUL);

    alu_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul_req),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod),
        .ovf     (mul_ovf)
    );
`else
    assign is_mul_req = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_prod   = '0;
    assign mul_ovf    = 1'b0;
    logic unused_mul_cfg;
    assign unused_mul_cfg = ^MUL_CYCLES ^ ^mul_prod ^ mul_ovf;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a request held high past DONE parks in WAIT_LOW so it is
    // never accepted a second time.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (alu_incoming) state_nxt = is_mul_req ? S_MUL : S_EXEC;
            S_EXEC:     state_nxt = S_DONE;
            S_MUL:      if (mul_done) state_nxt = S_DONE;
            S_DONE:     state_nxt = alu_incoming ? S_WAIT_LOW : S_IDLE;
            S_WAIT_LOW: if (!alu_incoming) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign alu_received = (state == S_DONE);
    assign alu_busy     = (state != S_IDLE);

    // Capture operands at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= alu_op;
            a_q  <= A;
            b_q  <= B;
        end
    end

    // Shifts run on a WIDTH+1 vector so the bit shifted out lands in the
    // extra position; a zero shift leaves that position at 0.
    assign sh    = b_q[3:0];
    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};
    assign shl_w = {1'b0, a_q} << sh;
    assign shr_w = {a_q, 1'b0} >> sh;
    assign sra_w = $signed({a_q, 1'b0}) >>> sh;

    // Single-cycle datapath on the latched operands; unknown ops give zeros.
    always_comb begin
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_q)
            ALU_ADD: begin
                res_y = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_y[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SUB: begin
                res_y = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
                res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_y[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND: res_y = a_q & b_q;
            ALU_OR:  res_y = a_q | b_q;
            ALU_XOR: res_y = a_q ^ b_q;
            ALU_NOT: res_y = ~a_q;
            ALU_SHL: begin
                res_y = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            ALU_SHR: begin
                res_y = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            ALU_SRA: begin
                res_y = sra_w[WIDTH:1];
                res_c = sra_w[0];
            end
            default: ;
        endcase
    end

    // Result registers hold until the next operation writes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y      <= '0;
            carry  <= 1'b0;
            signov <= 1'b0;
        end else if (state == S_EXEC) begin
            Y      <= res_y;
            carry  <= res_c;
            signov <= res_v;
        end else if ((state == S_MUL) && mul_done) begin
            Y      <= mul_prod;
            carry  <= 1'b0;
            signov <= mul_ovf;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; expectations queued at drive
// time and popped when alu_received fires. Covers both ALU_MUL_EN builds.
module tb_alu_core;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         alu_incoming = 1'b0;
    logic [3:0]   alu_op = '0;
    logic [W-1:0] A = '0, B = '0;
    logic         alu_received, carry, signov, alu_busy;
    logic [W-1:0] Y;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef ALU_MUL_EN
    localparam int MUL_LAT = 18;
`else
    localparam int MUL_LAT = 2;
`endif

    alu_core #(.WIDTH(W), .MUL_CYCLES(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_incoming (alu_incoming),
        .alu_op       (alu_op),
        .A            (A),
        .B            (B),
        .alu_received (alu_received),
        .Y            (Y),
        .carry        (carry),
        .signov       (signov),
        .alu_busy     (alu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_op = op; A = a; B = b; alu_incoming = 1'b1;
    endtask

    // Waits for the ack, scrambling the inputs after acceptance, then checks
    // latency and the popped expectation.
    task automatic wait_ack(input string tag, input int elat);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin A = ~A; B = ~B; alu_op = alu_op ^ 4'h3; end
        end while (!alu_received && n < 40);
        chk({tag, " latency"}, n, elat);
        e = sb.pop_front();
        chk({tag, " result"}, {Y, carry, signov}, {e.y, e.c, e.v});
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ey, input logic ec,
                          input logic ev, input int elat);
        exp_t e;
        e.y = ey; e.c = ec; e.v = ev;
        sb.push_back(e);
        start_req(op, a, b);
        wait_ack(tag, elat);
        @(posedge clk); #1;
        chk({tag, " pulse width"}, alu_received, 0);
        @(negedge clk); alu_incoming = 1'b0;
        @(posedge clk); #1;
        chk({tag, " back idle"}, alu_busy, 0);
    endtask

    initial begin
        int acks;
        exp_t e;

        // Reset state
        @(posedge clk); #1;
        chk("reset outputs", {Y, carry, signov, alu_received, alu_busy}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op("ADD 7FFF+1", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 2);
        run_op("SUB 0-1",    4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 2);
        run_op("ADD FFFF+1", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 2);
        run_op("SUB 8000-1", 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 2);
        run_op("AND",        4'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 2);
        run_op("OR",         4'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 2);
        run_op("XOR",        4'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 2);
        run_op("NOT",        4'd5, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1'b0, 2);
        run_op("SHL 8001<<1", 4'd6, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 2);
        run_op("SRA 8000>>>15", 4'd8, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 2);
        run_op("SHR 00FF>>0", 4'd7, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b0, 2);
        run_op("SHR 0003>>1", 4'd7, 16'h0003, 16'hFFF1, 16'h0001, 1'b1, 1'b0, 2);
        run_op("SHL amt 0",  4'd6, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0, 2);
        run_op("ILLEGAL 12", 4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 2);
        run_op("ADD pre",    4'd0, 16'h0100, 16'h0023, 16'h0123, 1'b0, 1'b0, 2);
`ifdef ALU_MUL_EN
        run_op("MUL FFFD*4",  4'd9, 16'hFFFD, 16'h0004, 16'hFFF4, 1'b0, 1'b0, MUL_LAT);
        run_op("MUL 100*100", 4'd9, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, MUL_LAT);
        run_op("MUL 8000*8000", 4'd9, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, MUL_LAT);
        run_op("MUL 7*FFFA",  4'd9, 16'h0007, 16'hFFFA, 16'hFFD6, 1'b0, 1'b0, MUL_LAT);
`else
        run_op("MUL disabled", 4'd9, 16'hFFFD, 16'h0004, 16'h0000, 1'b0, 1'b0, MUL_LAT);
`endif

        // Held request: no second ack, busy stays high
        e.y = 16'h0002; e.c = 1'b0; e.v = 1'b0; sb.push_back(e);
        start_req(4'd0, 16'h0001, 16'h0001);
        wait_ack("HOLD ack", 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("HOLD no reack", {alu_received, alu_busy}, 2'b01);
        end
        @(negedge clk); alu_incoming = 1'b0;
        e.y = 16'h0007; e.c = 1'b0; e.v = 1'b0; sb.push_back(e);
        start_req(4'd0, 16'h0003, 16'h0004);
        wait_ack("REARM ack", 2);
        @(negedge clk); alu_incoming = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of an operation
        start_req(4'd9, 16'h0100, 16'h0003);
`ifdef ALU_MUL_EN
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
`else
        @(posedge clk); #1;
`endif
        rst_n = 1'b0;
        #1;
        chk("RST mid-op outputs", {Y, carry, signov, alu_received, alu_busy}, 0);
        @(negedge clk); alu_incoming = 1'b0; rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (alu_received) acks++;
        end
        chk("RST no ack", acks, 0);
        run_op("ADD 2+3 after rst", 4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
